// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: FSM states, frame geometry and command byte layout.
// The frame builder is used by the master to load its 40-bit shift register.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int FRAME_BITS   = 40;
    localparam int CMD_BITS     = 8;
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 4;
    localparam int CMD_ADDR_LSB = 0;

    // Read frames clock out zeros in the data phase.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        wr,
        input logic [4:0]  addr,
        input logic [31:0] wdata
    );
        logic [CMD_BITS-1:0] cmd;
        cmd = '0;
        cmd[CMD_WR_BIT] = wr;
        cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
        return {cmd, (wr ? wdata : 32'h0)};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: o_tick in the last cycle of a CLK_DIV-cycle interval, o_pre_tick one cycle earlier.
// i_clr restarts the interval; it is asserted on every state entry so the count never wraps.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick,
    output logic o_pre_tick
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tick     = (r_cnt == 8'(CLK_DIV - 1));
    assign o_pre_tick = (r_cnt == 8'(CLK_DIV - 2));

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI register master: 40-bit frames (command byte + 32 data bits), oDone 83*CLK_DIV cycles after accept.
// iStart is only taken while idle; all SPI pins and status outputs come straight from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iWrite,
    input  logic [4:0]  iAddr,
    input  logic [31:0] iWData,
    output logic [31:0] oRData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oSPI_CLK,
    output logic        oSPI_CS,
    output logic        oSPI_MOSI,
    input  logic        iSPI_MISO
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_shreg;
    logic [31:0]             r_rx;
    logic [5:0]              r_bit_cnt;
    logic                    r_gap_half;
    logic                    r_wr;
    logic                    r_miso_s1;
    logic                    r_miso_s2;
    logic                    w_tick;
    logic                    w_pre_tick;
    logic                    w_div_clr;
    logic [FRAME_BITS-1:0]   w_frame;

    assign w_frame   = build_frame(iWrite, iAddr, iWData);
    assign w_div_clr = (r_state == ST_IDLE) || w_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .i_clk      (iCLK),
        .i_rst      (iRST),
        .i_clr      (w_div_clr),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= iSPI_MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_gap_half <= 1'b0;
            r_wr       <= 1'b0;
            oRData     <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oSPI_CLK   <= 1'b0;
            oSPI_CS    <= 1'b1;
            oSPI_MOSI  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_shreg   <= w_frame;
                        r_wr      <= iWrite;
                        r_bit_cnt <= '0;
                        oSPI_MOSI <= w_frame[FRAME_BITS-1];
                        oSPI_CS   <= 1'b0;
                        oBusy     <= 1'b1;
                        r_state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        oSPI_CLK <= 1'b1;
                        r_state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Last HIGH cycle: MISO has settled since the previous falling edge plus sync delay.
                    if (w_tick) begin
                        oSPI_CLK  <= 1'b0;
                        r_rx      <= {r_rx[30:0], r_miso_s2};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                        oSPI_MOSI <= r_shreg[FRAME_BITS-2];
                        r_state   <= (r_bit_cnt == LAST_BIT) ? ST_HOLD : ST_LOW;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        oSPI_CS    <= 1'b1;
                        r_gap_half <= 1'b0;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!r_gap_half) begin
                        if (w_tick) begin
                            r_gap_half <= 1'b1;
                        end
                    end else begin
                        if (w_pre_tick) begin
                            oDone <= 1'b1;
                            if (!r_wr) begin
                                oRData <= r_rx;
                            end
                        end
                        if (w_tick) begin
                            oBusy     <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural mode-0 register slave.
// Table of frames plus hand sequences for back-to-back, ignored starts and mid-frame reset.
module tb_spi_master;

    localparam int D = 4;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic        iWrite;
    logic [4:0]  iAddr;
    logic [31:0] iWData;
    logic [31:0] oRData;
    logic        oBusy;
    logic        oDone;
    logic        oSPI_CLK;
    logic        oSPI_CS;
    logic        oSPI_MOSI;
    logic        s_miso;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] s_regs [32];
    logic [39:0] s_rx;
    logic [31:0] s_tx;
    logic [39:0] s_last_frame;
    int          s_cnt;
    int          s_last_pulses;
    int          s_frames;

    spi_master #(.CLK_DIV(D)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iStart    (iStart),
        .iWrite    (iWrite),
        .iAddr     (iAddr),
        .iWData    (iWData),
        .oRData    (oRData),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oSPI_CLK  (oSPI_CLK),
        .oSPI_CS   (oSPI_CS),
        .oSPI_MOSI (oSPI_MOSI),
        .iSPI_MISO (s_miso)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (oDone === 1'b1) done_cnt++;
    end

    // Slave: samples MOSI on SCLK rise, updates MISO on SCLK fall, commits writes on CS rise.
    initial begin
        logic prev_clk;
        logic prev_cs;
        prev_clk = 1'b0;
        prev_cs  = 1'b1;
        for (int i = 0; i < 32; i++) s_regs[i] = 32'h0;
        s_regs[3] = 32'hDEAD_BEEF;
        s_regs[9] = 32'hCAFE_F00D;
        s_rx = '0; s_tx = '0; s_miso = 1'b0; s_cnt = 0;
        s_last_frame = '0; s_last_pulses = 0; s_frames = 0;
        forever begin
            @(oSPI_CLK or oSPI_CS);
            if (prev_cs === 1'b1 && oSPI_CS === 1'b0) begin
                s_cnt = 0; s_rx = '0; s_tx = '0; s_miso = 1'b0;
            end
            if (prev_cs === 1'b0 && oSPI_CS === 1'b1) begin
                s_last_frame  = s_rx;
                s_last_pulses = s_cnt;
                if (s_cnt == 40) begin
                    s_frames++;
                    if (s_rx[39]) s_regs[s_rx[36:32]] = s_rx[31:0];
                end
            end
            if (oSPI_CS === 1'b0 && prev_clk === 1'b0 && oSPI_CLK === 1'b1) begin
                s_rx = {s_rx[38:0], oSPI_MOSI};
                s_cnt++;
            end
            if (oSPI_CS === 1'b0 && prev_clk === 1'b1 && oSPI_CLK === 1'b0) begin
                if (s_cnt == 8) s_tx = s_regs[{1'b0, s_rx[3:0]}];
                else            s_tx = {s_tx[30:0], 1'b0};
                s_miso = (s_cnt >= 8) ? s_tx[31] : 1'b0;
            end
            prev_clk = oSPI_CLK;
            prev_cs  = oSPI_CS;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                             input logic [39:0] exp_frame, input logic [31:0] exp_rdata,
                             input int poke, input string tag);
        int cyc;
        bit got;
        @(negedge iCLK);
        iStart = 1'b1; iWrite = wr; iAddr = addr; iWData = wd;
        cyc = 0; got = 0;
        while (cyc < 2000 && !got) begin
            @(posedge iCLK);
            cyc++;
            #1;
            if (cyc == 1) begin
                iStart = 1'b0;
                chk({tag, " first busy"}, oBusy, 1'b1);
                chk({tag, " first cs"}, oSPI_CS, 1'b0);
                chk({tag, " first sclk"}, oSPI_CLK, 1'b0);
                chk({tag, " first mosi"}, oSPI_MOSI, exp_frame[39]);
            end
            if (poke != 0 && cyc == poke) begin
                iStart = 1'b1; iWrite = ~wr; iAddr = ~addr; iWData = ~wd;
            end
            if (poke != 0 && cyc == poke + 3) iStart = 1'b0;
            if (oDone === 1'b1) got = 1;
        end
        chk({tag, " done latency"}, 64'(cyc), 64'(83 * D));
        chk({tag, " rdata"}, oRData, exp_rdata);
        @(posedge iCLK);
        #1;
        chk({tag, " done pulse width"}, oDone, 1'b0);
        chk({tag, " busy after done"}, oBusy, 1'b0);
        chk({tag, " mosi frame"}, s_last_frame, exp_frame);
        chk({tag, " sclk pulses"}, 64'(s_last_pulses), 64'd40);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [39:0] exp_frame;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int k;
        int cyc;
        int rise;
        int fall2;
        int dones0;
        int frames0;
        logic prev_cs;

        vecs[0] = '{1'b1, 5'd17, 32'h00AB_CDEF, 40'h91_00AB_CDEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 5'd3,  32'hFFFF_FFFF, 40'h03_0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd5,  32'h1234_5678, 40'h85_1234_5678, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd5,  32'h0000_0000, 40'h05_0000_0000, 32'h1234_5678};
        vecs[4] = '{1'b0, 5'd9,  32'h5555_5555, 40'h09_0000_0000, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 5'd16, 32'hA5A5_5A5A, 40'h90_A5A5_5A5A, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 5'd19, 32'h0000_0000, 40'h13_0000_0000, 32'hDEAD_BEEF};

        // Reset, with iStart asserted throughout to show it is ignored.
        iRST = 1'b1; iStart = 1'b1; iWrite = 1'b1; iAddr = 5'd1; iWData = 32'h1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst cs", oSPI_CS, 1'b1);
        chk("rst sclk", oSPI_CLK, 1'b0);
        chk("rst mosi", oSPI_MOSI, 1'b0);
        chk("rst busy", oBusy, 1'b0);
        chk("rst done", oDone, 1'b0);
        chk("rst rdata", oRData, 32'h0);
        @(negedge iCLK);
        iStart = 1'b0; iRST = 1'b0;
        @(posedge iCLK);
        #1;
        chk("post-rst cs", oSPI_CS, 1'b1);
        chk("post-rst busy", oBusy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_frame,
                      vecs[i].exp_rdata, 0, $sformatf("vec%0d", i));
            if (vecs[i].wr) chk($sformatf("vec%0d slave reg", i), s_regs[vecs[i].addr], vecs[i].wdata);
        end

        // Starts with different inputs mid-frame must not disturb the latched frame.
        frames0 = s_frames;
        run_frame(1'b1, 5'd2, 32'h1111_2222, 40'h82_1111_2222, 32'hDEAD_BEEF, 50, "ignore");
        repeat (3 * D) @(posedge iCLK);
        #1;
        chk("ignore no extra frame busy", oBusy, 1'b0);
        chk("ignore frame count", 64'(s_frames - frames0), 64'd1);
        chk("ignore slave reg", s_regs[2], 32'h1111_2222);

        // Back-to-back with iStart held high.
        @(negedge iCLK);
        iStart = 1'b1; iWrite = 1'b1; iAddr = 5'd1; iWData = 32'h0F0F_0F0F;
        frames0 = s_frames; dones0 = done_cnt;
        rise = -1; fall2 = -1; prev_cs = 1'b1; cyc = 0;
        while (cyc < 3 * 83 * D && fall2 < 0) begin
            @(posedge iCLK);
            cyc++;
            #1;
            if (prev_cs === 1'b0 && oSPI_CS === 1'b1 && rise < 0) rise = cyc;
            if (prev_cs === 1'b1 && oSPI_CS === 1'b0 && rise >= 0) fall2 = cyc;
            prev_cs = oSPI_CS;
        end
        iStart = 1'b0;
        chk("b2b second cs fall seen", 64'(fall2 > 0), 64'd1);
        chk("b2b cs high time", 64'((fall2 - rise) >= 2 * D), 64'd1);
        chk("b2b first done", 64'(done_cnt - dones0), 64'd1);
        k = 0;
        while (k < 1000 && (done_cnt - dones0) < 2) begin
            @(posedge iCLK);
            k++;
        end
        repeat (4 * D) @(posedge iCLK);
        #1;
        chk("b2b done count", 64'(done_cnt - dones0), 64'd2);
        chk("b2b frame count", 64'(s_frames - frames0), 64'd2);
        chk("b2b last frame", s_last_frame, 40'h81_0F0F_0F0F);
        chk("b2b idle", oBusy, 1'b0);

        // Reset at bit 20 aborts the frame.
        @(negedge iCLK);
        iStart = 1'b1; iWrite = 1'b1; iAddr = 5'd4; iWData = 32'h4444_AAAA;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        k = 0;
        while (k < 1000 && s_cnt != 20) begin
            @(posedge iCLK);
            k++;
            #1;
        end
        chk("abort reached bit 20", 64'(s_cnt), 64'd20);
        dones0 = done_cnt;
        @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        chk("abort cs", oSPI_CS, 1'b1);
        chk("abort sclk", oSPI_CLK, 1'b0);
        chk("abort busy", oBusy, 1'b0);
        @(negedge iCLK);
        iRST = 1'b0;
        repeat (100 * D) @(posedge iCLK);
        #1;
        chk("abort no done", 64'(done_cnt - dones0), 64'd0);
        chk("abort no write", s_regs[4], 32'h0);
        run_frame(1'b1, 5'd4, 32'h4444_AAAA, 40'h84_4444_AAAA, 32'h0, 0, "after abort");
        chk("after abort slave reg", s_regs[4], 32'h4444_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
